// File: rtl/spike_aer_encoder.sv
// Address-event encoder: latches neuron spikes, picks one per cycle round-robin and
// queues {neuron index, timestamp} events in a first-word-fall-through FIFO.
module spike_aer_encoder #(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         spike_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [$clog2(N)-1:0] aer_addr,
    output logic [TS_W-1:0]      aer_time,
    output logic                 fifo_full,
    output logic [7:0]           drop_count
);

    localparam int AW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TS_W-1:0] ts;
    logic [N-1:0]    pending;
    logic [N-1:0]    grant;
    logic [N-1:0]    collide;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   gidx;
    logic            found;
    int              idx;

    logic [AW-1:0]   addr_mem [DEPTH];
    logic [TS_W-1:0] time_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;
    logic            has_room;
    logic            push;
    logic            pop;

    logic [15:0]     ncol;
    logic [16:0]     drop_sum;
    logic [7:0]      drop_next;

    // Room is judged on the registered occupancy, so a same-cycle pop never frees a slot.
    assign has_room  = occ < CW'(DEPTH);
    assign fifo_full = occ == CW'(DEPTH);
    assign aer_valid = occ != '0;
    assign push      = |grant;
    assign pop       = aer_valid & aer_ready;

    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign aer_addr  = aer_valid ? addr_mem[rd_ptr] : '0;
    assign aer_time  = aer_valid ? time_mem[rd_ptr] : '0;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && has_room && pending[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = AW'(idx);
            end
        end
    end

    assign collide = spike_in & pending & ~grant;

    always_comb begin
        ncol = '0;
        for (int i = 0; i < N; i++) begin
            ncol = ncol + 16'(collide[i]);
        end
        drop_sum  = 17'(drop_count) + 17'(ncol);
        drop_next = (drop_sum > 17'd255) ? 8'hff : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts         <= '0;
            pending    <= '0;
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            drop_count <= '0;
        end else begin
            ts         <= ts + 1'b1;
            pending    <= (pending & ~grant) | spike_in;
            drop_count <= drop_next;
            if (push) begin
                ptr    <= (gidx == AW'(N - 1)) ? '0 : gidx + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (!push && pop) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= gidx;
            time_mem[wr_ptr] <= ts;
        end
    end

endmodule
